adder_issue_controller: RTL and testbench
=========================================

// Module: adder_issue_controller
// PURPOSE
//  Sequential front-end for the combinational 64-bit ripple-carry adder (ripplecarryadder: A, B -> SUM).
//  Accepts operand pairs on a valid/ready handshake, holds them stable on the adder inputs for a
//  programmable settle time covering worst-case ripple, then samples SUM into an output register.
//  Derives carry-out and signed overflow from operand MSBs and the sampled SUM, which the adder omits.
// PARAMETERS
//  WIDTH          64  operand/sum width; must match the adder instance
//  SETTLE_CYCLES  4   clock edges between operand launch and SUM capture; legal range 1..255
// PORTS
//  CLK        in   1      single clock, all state updates on rising edge
//  RST        in   1      synchronous, active-high reset
//  IN_VALID   in   1      operand pair IN_A/IN_B present
//  IN_READY   out  1      controller can accept an operand pair this cycle
//  IN_A       in   WIDTH  operand A
//  IN_B       in   WIDTH  operand B
//  ADD_A      out  WIDTH  registered operand A, drives adder .A
//  ADD_B      out  WIDTH  registered operand B, drives adder .B
//  ADD_SUM    in   WIDTH  adder .SUM result
//  OUT_VALID  out  1      result registers hold a valid result
//  OUT_READY  in   1      consumer accepts the result
//  OUT_SUM    out  WIDTH  captured sum
//  OUT_COUT   out  1      unsigned carry-out of bit WIDTH-1
//  OUT_OVF    out  1      two's-complement signed overflow
//  BUSY       out  1      high in SETTLE or HOLD
// BEHAVIOUR
//  Reset: state=IDLE. ADD_A, ADD_B, OUT_SUM, OUT_COUT, OUT_OVF, OUT_VALID, BUSY and the counter are all 0.
//   RST overrides everything, including mid-SETTLE and mid-HOLD. An in-flight result is dropped.
//  States:
//   IDLE    IN_READY=1. IN_VALID -> latch IN_A/IN_B into ADD_A/ADD_B, cnt=SETTLE_CYCLES-1, go SETTLE.
//   SETTLE  IN_READY=0. If cnt!=0: cnt-=1. If cnt==0: capture ADD_SUM, COUT and OVF, set OUT_VALID=1, go HOLD.
//   HOLD    IN_READY=OUT_READY (combinational pass-through). On OUT_READY, the result is consumed:
//            - with IN_VALID: latch new operands, reload cnt, OUT_VALID=0, go SETTLE;
//            - without IN_VALID: OUT_VALID=0, go IDLE.
//           Without OUT_READY: all outputs hold.
//  Latency: operands accepted at edge k; OUT_VALID=1 after edge k+SETTLE_CYCLES.
//   Back-to-back throughput: one result every SETTLE_CYCLES+1 cycles.
//  Operand stability: ADD_A/ADD_B change only on an accepted IN handshake.
//   They stay constant through SETTLE and HOLD.
//  Result outputs change only on capture or reset. OUT_VALID never drops without OUT_READY, except on RST.
//  Flags are computed from MSBs only (a=ADD_A[W-1], b=ADD_B[W-1], s=ADD_SUM[W-1]):
//   COUT = (a&b) | ((a^b)&~s)
//   OVF  = (a==b) & (s!=a)
//  SUM wraps modulo 2^WIDTH. There is no carry-in.
//  SETTLE_CYCLES=1: cnt loads 0, so capture occurs on the first SETTLE edge.
//  IN_VALID with IN_READY=0 is ignored. The upstream source holds its data until accepted.
// STRUCTURE
//  Shared include adder_defs.vh holds:
//   - state encodings ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_HOLD=2'd2;
//   - the default WIDTH;
//   - an 8-bit counter width constant.
//  One natural sub-module, settle_counter: load/decrement/zero-flag down-counter.
//   The FSM, operand registers and result registers stay in this module.
//  The testbench instantiates this block together with a real ripplecarryadder.
// TESTING
//  1. A=64'h7FFFFFFFFFFFFFFF, B=64'h7FFFFFFFFFFFFFFF, SETTLE=4
//     -> OUT_SUM=64'hFFFFFFFFFFFFFFFE, COUT=0, OVF=1; OUT_VALID exactly 4 edges after accept.
//  2. A=64'hFFFFFFFFFFFFFFFF, B=64'h1
//     -> OUT_SUM=0, COUT=1, OVF=0 (wrap-around).
//  3. A=64'h8000000000000000, B=64'h8000000000000000
//     -> OUT_SUM=0, COUT=1, OVF=1.
//  4. OUT_READY held low 10 cycles, then a new IN_VALID offered
//     -> IN_READY=0 and OUT_SUM stable throughout;
//     -> OUT_READY=1 with IN_VALID=1 accepts the new pair the same cycle and re-enters SETTLE.
//  5. RST asserted at SETTLE cnt=2
//     -> next cycle state IDLE, all outputs 0, no OUT_VALID pulse.
//  6. SETTLE_CYCLES=1 build, 3 back-to-back pairs with OUT_READY=1
//     -> a result every 2 cycles; ADD_A/ADD_B are never changed outside an accept.

Source files
------------

// File: rtl/adder_issue_controller_pkg.sv
// Shared definitions for the adder issue controller: state encoding,
// default operand width and the settle counter width.
package adder_issue_controller_pkg;

  // Controller states; the fourth encoding is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Default operand/sum width, matching the 64-bit ripple-carry adder.
  localparam int DEF_WIDTH = 64;

  // The settle counter is 8 bits wide, so SETTLE_CYCLES may be 1..255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/adder_issue_controller_settle_counter.sv
// Load / decrement down-counter with a zero flag. It times how long the
// operands sit on the adder inputs before the sum is sampled.
module adder_issue_controller_settle_counter
  import adder_issue_controller_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: a load wins over a decrement, and the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ripplecarryadder.sv
// Combinational ripple-carry adder, SUM = A + B modulo 2^WIDTH, with no
// carry-in and no carry-out. Its worst-case delay is the full carry chain.
module ripplecarryadder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM
);

  // carry[i] is the carry into bit i.
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign SUM[i] = A[i] ^ B[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (A[i] & B[i]) | ((A[i] ^ B[i]) & carry[i]);
    end
  end

endmodule

// File: rtl/adder_issue_controller.sv
// Sequential front-end for the combinational ripple-carry adder. It latches
// an operand pair and holds it on the adder for SETTLE_CYCLES edges. It then
// registers the sum, plus carry-out and signed overflow rebuilt from the MSBs,
// and holds the result until the consumer takes it.
module adder_issue_controller
  import adder_issue_controller_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  input  logic [WIDTH-1:0] ADD_SUM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic             OUT_COUT,
  output logic             OUT_OVF,
  output logic             BUSY
);

  // The counter reloads with SETTLE_CYCLES-1 so that capture lands exactly
  // SETTLE_CYCLES edges after the accepting edge.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  // Carry-out of the MSB, inferred from the operand MSBs and the sum MSB.
  function automatic logic calc_cout(input logic a, input logic b, input logic s);
    return (a & b) | ((a ^ b) & ~s);
  endfunction

  // Signed overflow: the operands share a sign and the sum has the other one.
  function automatic logic calc_ovf(input logic a, input logic b, input logic s);
    return (a == b) && (s != a);
  endfunction

  state_e state_q, state_d;

  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             busy;
  logic             accept;
  logic             capture;
  logic             consume;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  adder_issue_controller_settle_counter #(
    .CW(CNT_W)
  ) u_settle_counter (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: settle until the counter hits zero, then hold until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (IN_VALID) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_zero) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (OUT_READY) state_d = IN_VALID ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded controls. In HOLD, ready follows OUT_READY so that a new pair
  // can be taken on the same edge the old result leaves.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    capture  = 1'b0;
    consume  = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SETTLE: begin
        busy    = 1'b1;
        capture = cnt_zero;
        cnt_dec = ~cnt_zero;
      end
      ST_HOLD: begin
        busy     = 1'b1;
        in_ready = OUT_READY;
        consume  = OUT_READY;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
    accept = IN_VALID & in_ready;
  end

  // Operand and result next values. The operands move only on an accept, and
  // the result moves only on a capture. A consumed result keeps its value on
  // the outputs, and only OUT_VALID falls.
  always_comb begin
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      add_a_d = IN_A;
      add_b_d = IN_B;
    end
    if (capture) begin
      out_sum_d   = ADD_SUM;
      out_cout_d  = calc_cout(add_a_q[WIDTH-1], add_b_q[WIDTH-1], ADD_SUM[WIDTH-1]);
      out_ovf_d   = calc_ovf(add_a_q[WIDTH-1], add_b_q[WIDTH-1], ADD_SUM[WIDTH-1]);
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  // Operand and result registers. Reset clears them, and a result still in flight is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready;
  assign BUSY      = busy;
  assign ADD_A     = add_a_q;
  assign ADD_B     = add_b_q;
  assign OUT_SUM   = out_sum_q;
  assign OUT_COUT  = out_cout_q;
  assign OUT_OVF   = out_ovf_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_adder_issue_controller.sv
// Bench for adder_issue_controller. Instance 0 uses SETTLE_CYCLES=4 and
// instance 1 uses SETTLE_CYCLES=1. Each instance drives a real ripplecarryadder.
module tb_adder_issue_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [2];
  logic        out_ready[2];
  logic [63:0] in_a     [2];
  logic [63:0] in_b     [2];
  logic        in_ready [2];
  logic        out_valid[2];
  logic        cout     [2];
  logic        ovf      [2];
  logic        busy     [2];
  logic [63:0] add_a    [2];
  logic [63:0] add_b    [2];
  logic [63:0] add_sum  [2];
  logic [63:0] out_sum  [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  adder_issue_controller #(.WIDTH(64), .SETTLE_CYCLES(4)) u_dut0 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .IN_A(in_a[0]), .IN_B(in_b[0]), .ADD_A(add_a[0]), .ADD_B(add_b[0]),
    .ADD_SUM(add_sum[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
    .OUT_SUM(out_sum[0]), .OUT_COUT(cout[0]), .OUT_OVF(ovf[0]), .BUSY(busy[0])
  );
  ripplecarryadder #(.WIDTH(64)) u_add0 (.A(add_a[0]), .B(add_b[0]), .SUM(add_sum[0]));

  adder_issue_controller #(.WIDTH(64), .SETTLE_CYCLES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .IN_A(in_a[1]), .IN_B(in_b[1]), .ADD_A(add_a[1]), .ADD_B(add_b[1]),
    .ADD_SUM(add_sum[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
    .OUT_SUM(out_sum[1]), .OUT_COUT(cout[1]), .OUT_OVF(ovf[1]), .BUSY(busy[1])
  );
  ripplecarryadder #(.WIDTH(64)) u_add1 (.A(add_a[1]), .B(add_b[1]), .SUM(add_sum[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: an operand pair is in flight for a number of edges.
  // The sum comes from 65-bit arithmetic, and a result waits until it is taken.
  logic        m_infl [2];
  int          m_wait [2];
  logic        m_valid[2];
  logic [63:0] m_a    [2];
  logic [63:0] m_b    [2];
  logic [63:0] m_sum  [2];
  logic        m_cout [2];
  logic        m_ovf  [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic exp_ready(input int i);
    return (!m_infl[i] && !m_valid[i]) || (m_valid[i] && out_ready[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic logic        acc  = in_valid[i] && exp_ready(i);
      automatic logic [64:0] full = {1'b0, m_a[i]} + {1'b0, m_b[i]};
      if (rst) begin
        m_infl[i] <= 1'b0; m_wait[i] <= 0; m_valid[i] <= 1'b0;
        m_a[i] <= '0; m_b[i] <= '0; m_sum[i] <= '0; m_cout[i] <= 1'b0; m_ovf[i] <= 1'b0;
      end else begin
        if (m_infl[i]) begin
          if (m_wait[i] == 1) begin
            m_infl[i]  <= 1'b0;
            m_wait[i]  <= 0;
            m_valid[i] <= 1'b1;
            m_sum[i]   <= full[63:0];
            m_cout[i]  <= full[64];
            m_ovf[i]   <= (m_a[i][63] == m_b[i][63]) && (full[63] != m_a[i][63]);
          end else begin
            m_wait[i] <= m_wait[i] - 1;
          end
        end
        if (m_valid[i] && out_ready[i]) m_valid[i] <= 1'b0;
        if (acc) begin
          m_a[i] <= in_a[i]; m_b[i] <= in_b[i];
          m_infl[i] <= 1'b1; m_wait[i] <= settle_of(i);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d in_ready", i),  64'(in_ready[i]),  64'(exp_ready(i)));
        chk($sformatf("u%0d busy", i),      64'(busy[i]),      64'(m_infl[i] || m_valid[i]));
        chk($sformatf("u%0d add_a", i),     add_a[i],          m_a[i]);
        chk($sformatf("u%0d add_b", i),     add_b[i],          m_b[i]);
        chk($sformatf("u%0d out_valid", i), 64'(out_valid[i]), 64'(m_valid[i]));
        chk($sformatf("u%0d out_sum", i),   out_sum[i],        m_sum[i]);
        chk($sformatf("u%0d out_cout", i),  64'(cout[i]),      64'(m_cout[i]));
        chk($sformatf("u%0d out_ovf", i),   64'(ovf[i]),       64'(m_ovf[i]));
      end
    end
  end

  // Offer a pair and wait, within a bound, for the accepting edge. Returns #1 after that edge.
  task automatic send(input int i, input logic [63:0] a, input logic [63:0] b, output longint t_acc);
    in_a[i] = a; in_b[i] = b; in_valid[i] = 1'b1;
    t_acc = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready[i]) begin
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid[i] = 1'b0;
        break;
      end
    end
    chk($sformatf("u%0d send_accepted", i), 64'(t_acc >= 0), 64'd1);
  endtask

  // Count the edges after an accept until OUT_VALID rises, up to a bound.
  task automatic wait_valid(input int i, output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid[i]) begin lat = n; break; end
    end
  endtask

  task automatic run_one(input string nm, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] es, input logic ec, input logic eo);
    longint t;
    int lat;
    send(0, a, b, t);
    wait_valid(0, lat);
    chk({nm, " latency"}, 64'(lat), 64'd4);
    chk({nm, " sum"},  out_sum[0], es);
    chk({nm, " cout"}, 64'(cout[0]), 64'(ec));
    chk({nm, " ovf"},  64'(ovf[0]),  64'(eo));
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk({nm, " consumed"}, 64'(out_valid[0]), 64'd0);
    chk({nm, " idle"},     64'(busy[0]),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0, t1, t2;
    int lat;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset in_ready", i),  64'(in_ready[i]),  64'd1);
      chk($sformatf("u%0d reset out_valid", i), 64'(out_valid[i]), 64'd0);
      chk($sformatf("u%0d reset busy", i),      64'(busy[i]),      64'd0);
      chk($sformatf("u%0d reset add_a", i),     add_a[i],          64'd0);
      chk($sformatf("u%0d reset out_sum", i),   out_sum[i],        64'd0);
    end
    rst = 1'b0;
    chk_en = 1'b1;

    // Signed overflow without carry-out, then wrap-around, then both flags.
    run_one("t1", 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1);
    run_one("t2", 64'hFFFFFFFFFFFFFFFF, 64'h1,                64'h0,               1'b1, 1'b0);
    run_one("t3", 64'h8000000000000000, 64'h8000000000000000, 64'h0,               1'b1, 1'b1);
    run_one("t3b", 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);

    // Back-pressure: the result is held while a new pair waits, then both move on one edge.
    send(0, 64'd1, 64'd2, t0);
    wait_valid(0, lat);
    chk("t4 latency", 64'(lat), 64'd4);
    in_a[0] = 64'd30; in_b[0] = 64'd40; in_valid[0] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("t4 hold in_ready", 64'(in_ready[0]), 64'd0);
      chk("t4 hold out_sum",  out_sum[0],       64'd3);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("t4 ready passthrough", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    chk("t4 resettle busy",  64'(busy[0]),      64'd1);
    chk("t4 resettle valid", 64'(out_valid[0]), 64'd0);
    chk("t4 new add_a",      add_a[0],          64'd30);
    wait_valid(0, lat);
    chk("t4 second latency", 64'(lat), 64'd4);
    chk("t4 second sum", out_sum[0], 64'd70);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Reset in the middle of SETTLE, two counts before capture.
    send(0, 64'h55, 64'h66, t0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5 in_ready", 64'(in_ready[0]),  64'd1);
    chk("t5 busy",     64'(busy[0]),      64'd0);
    chk("t5 add_a",    add_a[0],          64'd0);
    chk("t5 out_sum",  out_sum[0],        64'd0);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      chk("t5 no valid pulse", 64'(out_valid[0]), 64'd0);
    end

    // SETTLE_CYCLES=1, three pairs back to back with the consumer always ready.
    out_ready[1] = 1'b1;
    send(1, 64'd10, 64'd20, t0);
    send(1, 64'd100, 64'd200, t1);
    send(1, 64'hFFFFFFFFFFFFFFF0, 64'h20, t2);
    chk("t6 period 1-2", 64'(t1 - t0), 64'd20);
    chk("t6 period 2-3", 64'(t2 - t1), 64'd20);
    wait_valid(1, lat);
    chk("t6 latency", 64'(lat), 64'd1);
    chk("t6 last sum",  out_sum[1], 64'h10);
    chk("t6 last cout", 64'(cout[1]), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6 drained", 64'(out_valid[1]), 64'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
